vend_led_sched: RTL and testbench



---
 rtl/vend_led_pkg.sv | 19 +
 rtl/vend_tick_500ms.sv | 27 ++
 rtl/vend_led_sched.sv | 151 +++++++++++++++
 tb/tb_vend_led_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vend_led_pkg.sv
// Shared state encodings and LED constants for the vending-machine LED scheduler.
package vend_led_pkg;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    FLOW      = 6'b000010,
    BLINK_ON  = 6'b000100,
    BLINK_OFF = 6'b001000,
    GAP       = 6'b010000,
    FAULT     = 6'b100000
  } state_t;

  // LEDs are active-low: a 0 bit lights the LED.
  localparam logic [3:0] LED_OFF = 4'b1111;
  localparam logic [3:0] LED_ALL = 4'b0000;
  localparam logic [3:0] FAULT_A = 4'b1001;
  localparam logic [3:0] FAULT_B = 4'b0110;

endpackage

// File: rtl/vend_tick_500ms.sv
// 500 ms tick generator: counts while run is high, restarts on clr.
module vend_tick_500ms #(
  parameter logic [31:0] CNT_500MS_MAX = 32'd24_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  logic [31:0] timer;

  assign tick = run && (timer == CNT_500MS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 32'd0;
    end else if (clr) begin
      timer <= 32'd0;
    end else if (run) begin
      if (tick) timer <= 32'd0;
      else      timer <= timer + 32'd1;
    end
  end

endmodule

// File: rtl/vend_led_sched.sv
// LED scheduler sharing the board LEDs between dispense flow, change blink and fault.
// Fault handling is compiled only when VEND_FAULT_EN is defined.
module vend_led_sched
  import vend_led_pkg::*;
#(
  parameter logic [31:0] CNT_500MS_MAX = 32'd24_999_999,
  parameter int          FLOW_SLOTS    = 4,
  parameter int          BLINK_CNT     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dispense_req,
  input  logic       change_req,
  input  logic       fault,
  input  logic [3:0] flow_led,
  output logic       flow_en,
  output logic [3:0] led,
  output logic       busy
);

  localparam logic [3:0] FLOW_LAST  = 4'(FLOW_SLOTS - 1);
  localparam logic [3:0] BLINK_LAST = 4'(BLINK_CNT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] slot;
  logic [3:0] slot_next;
  logic       pend_disp;
  logic       pend_chg;
  logic       clr_disp;
  logic       clr_chg;
  logic       tick;
  logic       run;
  logic       state_change;

  assign run          = (state != IDLE);
  assign state_change = (state_next != state);

  vend_tick_500ms #(
    .CNT_500MS_MAX(CNT_500MS_MAX)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clr  (state_change),
    .tick (tick)
  );

  always_comb begin
    state_next = state;
    slot_next  = slot;
    clr_disp   = 1'b0;
    clr_chg    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_disp) begin
          state_next = FLOW;
          clr_disp   = 1'b1;
          slot_next  = 4'd0;
        end else if (pend_chg) begin
          state_next = BLINK_ON;
          clr_chg    = 1'b1;
          slot_next  = 4'd0;
        end
      end
      FLOW: begin
        if (tick) begin
          if (slot == FLOW_LAST) state_next = GAP;
          else                   slot_next  = slot + 4'd1;
        end
      end
      BLINK_ON: begin
        if (tick) state_next = BLINK_OFF;
      end
      BLINK_OFF: begin
        if (tick) begin
          if (slot == BLINK_LAST) begin
            state_next = GAP;
          end else begin
            slot_next  = slot + 4'd1;
            state_next = BLINK_ON;
          end
        end
      end
      GAP: begin
        if (tick) state_next = IDLE;
      end
`ifdef VEND_FAULT_EN
      FAULT: begin
        if (!fault) state_next = GAP;
      end
`endif
      default: state_next = IDLE;
    endcase
`ifdef VEND_FAULT_EN
    // Fault pre-empts everything; pending jobs stay queued for afterwards.
    if (fault) begin
      state_next = FAULT;
      clr_disp   = 1'b0;
      clr_chg    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot      <= 4'd0;
      pend_disp <= 1'b0;
      pend_chg  <= 1'b0;
    end else begin
      state     <= state_next;
      slot      <= slot_next;
      pend_disp <= dispense_req | (pend_disp & ~clr_disp);
      pend_chg  <= change_req | (pend_chg & ~clr_chg);
    end
  end

`ifdef VEND_FAULT_EN
  logic fault_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fault_phase <= 1'b0;
    else if (state != FAULT) fault_phase <= 1'b0;
    else if (tick)           fault_phase <= ~fault_phase;
  end
`else
  logic unused_fault;
  assign unused_fault = fault;
`endif

  // LEDs follow the state register one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= LED_OFF;
    end else begin
      case (state)
        FLOW:     led <= flow_led;
        BLINK_ON: led <= LED_ALL;
`ifdef VEND_FAULT_EN
        FAULT:    led <= fault_phase ? FAULT_B : FAULT_A;
`endif
        default:  led <= LED_OFF;
      endcase
    end
  end

  assign flow_en = (state == FLOW);
  assign busy    = (state != IDLE) | pend_disp | pend_chg;

endmodule

// File: tb/tb_vend_led_sched.sv
// Directed bench for vend_led_sched with a 10-cycle tick, 4 flow slots and 3 blinks.
module tb_vend_led_sched;

  localparam int C_I   = 0;
  localparam int C_P   = 1;
  localparam int C_F   = 2;
  localparam int C_ON  = 3;
  localparam int C_OFF = 4;
  localparam int C_G   = 5;
  localparam int C_XA  = 6;
  localparam int C_XB  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dispense_req = 1'b0;
  logic       change_req = 1'b0;
  logic       fault = 1'b0;
  logic [3:0] flow_led = 4'hF;
  logic       flow_en;
  logic [3:0] led;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         codes[$];
  logic [2:0] stim [0:255];

  vend_led_sched #(
    .CNT_500MS_MAX(32'd9),
    .FLOW_SLOTS   (4),
    .BLINK_CNT    (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dispense_req(dispense_req),
    .change_req  (change_req),
    .fault       (fault),
    .flow_led    (flow_led),
    .flow_en     (flow_en),
    .led         (led),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] fl_pat(input int k);
    return 4'(k * 7 + 3);
  endfunction

  // Expected LED value after one cycle in the given plan state.
  function automatic logic [3:0] exp_led(input int code, input logic [3:0] fl);
    case (code)
      C_F:     return fl;
      C_ON:    return 4'b0000;
      C_XA:    return 4'b1001;
      C_XB:    return 4'b0110;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic clear_plan();
    codes.delete();
    for (int i = 0; i < 256; i++) stim[i] = 3'b000;
  endtask

  task automatic add_seg(input int code, input int len);
    for (int i = 0; i < len; i++) codes.push_back(code);
  endtask

  task automatic add_blinks();
    for (int i = 0; i < 3; i++) begin
      add_seg(C_ON, 10);
      add_seg(C_OFF, 10);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    dispense_req = 1'b0;
    change_req   = 1'b0;
    fault        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input string name);
    int prev;
    do_reset();
    for (int k = 0; k < codes.size(); k++) begin
      dispense_req = stim[k][0];
      change_req   = stim[k][1];
      fault        = stim[k][2];
      flow_led     = fl_pat(k);
      @(negedge clk);
      prev = (k == 0) ? C_I : codes[k-1];
      checkOutput($sformatf("%s c%0d led", name, k), led, exp_led(prev, fl_pat(k - 1)));
      checkOutput($sformatf("%s c%0d flow_en", name, k), {3'b000, flow_en},
                  {3'b000, codes[k] == C_F});
      checkOutput($sformatf("%s c%0d busy", name, k), {3'b000, busy},
                  {3'b000, codes[k] != C_I});
      @(posedge clk);
      #1;
    end
    dispense_req = 1'b0;
    change_req   = 1'b0;
    fault        = 1'b0;
  endtask

  initial begin
    $display("[TB] start");

    clear_plan();
    add_seg(C_I, 100);
    applyStimulus("idle");

    clear_plan();
    stim[0] = 3'b001;
    add_seg(C_I, 1); add_seg(C_P, 1); add_seg(C_F, 40); add_seg(C_G, 10); add_seg(C_I, 8);
    applyStimulus("disp");

    clear_plan();
    stim[0] = 3'b010;
    add_seg(C_I, 1); add_seg(C_P, 1); add_blinks(); add_seg(C_G, 10); add_seg(C_I, 8);
    applyStimulus("chg");

    clear_plan();
    stim[0] = 3'b011;
    add_seg(C_I, 1); add_seg(C_P, 1); add_seg(C_F, 40); add_seg(C_G, 10);
    add_seg(C_P, 1); add_blinks(); add_seg(C_G, 10); add_seg(C_I, 5);
    applyStimulus("both");

    clear_plan();
    stim[0] = 3'b001; stim[10] = 3'b001; stim[20] = 3'b001;
    add_seg(C_I, 1); add_seg(C_P, 1); add_seg(C_F, 40); add_seg(C_G, 10);
    add_seg(C_P, 1); add_seg(C_F, 40); add_seg(C_G, 10); add_seg(C_I, 10);
    applyStimulus("drop");

    // Fault held high for cycles 15..44, change request arrives mid-fault.
    clear_plan();
    stim[0] = 3'b001;
    for (int k = 15; k <= 44; k++) stim[k] = 3'b100;
    stim[20] = 3'b110;
`ifdef VEND_FAULT_EN
    add_seg(C_I, 1); add_seg(C_P, 1); add_seg(C_F, 14);
    add_seg(C_XA, 10); add_seg(C_XB, 10); add_seg(C_XA, 10); add_seg(C_G, 10);
    add_seg(C_P, 1); add_blinks(); add_seg(C_G, 10); add_seg(C_I, 5);
`else
    add_seg(C_I, 1); add_seg(C_P, 1); add_seg(C_F, 40); add_seg(C_G, 10);
    add_seg(C_P, 1); add_blinks(); add_seg(C_G, 10); add_seg(C_I, 5);
`endif
    applyStimulus("fault");

    // Reset in the middle of a flow with a second dispense pending.
    clear_plan();
    do_reset();
    dispense_req = 1'b1;
    @(posedge clk); #1 dispense_req = 1'b0;
    repeat (9) @(posedge clk);
    #1 dispense_req = 1'b1;
    @(posedge clk); #1 dispense_req = 1'b0;
    flow_led = 4'b0101;
    @(negedge clk);
    checkOutput("midrst pre flow_en", {3'b000, flow_en}, 4'b0001);
    checkOutput("midrst pre busy", {3'b000, busy}, 4'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midrst pre led", led, 4'b0101);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst led", led, 4'b1111);
    checkOutput("midrst flow_en", {3'b000, flow_en}, 4'b0000);
    checkOutput("midrst busy", {3'b000, busy}, 4'b0000);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst post c%0d flow_en", k), {3'b000, flow_en}, 4'b0000);
      checkOutput($sformatf("midrst post c%0d busy", k), {3'b000, busy}, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
